// File: rtl/seq_divide_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// counter sizing helper and result-flag bit positions.
package seq_divide_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  localparam int FLAG_DZ   = 0;
  localparam int FLAG_OV   = 1;
  localparam int NUM_FLAGS = 2;

  // Bits needed to hold any value in 0..value-1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/seq_divide_if.sv
// Operand/result bundle of the divider: start/ready/done handshake plus
// operands, sign controls, results and status flags.
interface seq_divide_if #(
  parameter int width_n = 8,
  parameter int width_d = 8
);
  logic               start;
  logic [width_n-1:0] numer;
  logic [width_d-1:0] denom;
  logic               signn;
  logic               signd;
  logic               ready;
  logic               done;
  logic [width_n-1:0] quotient;
  logic [width_d-1:0] remain;
  logic               div_by_zero;
  logic               overflow;

  modport master (
    output start, numer, denom, signn, signd,
    input  ready, done, quotient, remain, div_by_zero, overflow
  );

  modport slave (
    input  start, numer, denom, signn, signd,
    output ready, done, quotient, remain, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divide_step.sv
// One restoring-division iteration: shift a numerator bit into the partial
// remainder and subtract the divisor when it fits.
module seq_divide_step #(
  parameter int width_d = 8
) (
  input  logic [width_d:0]   i_partial,
  input  logic [width_d-1:0] i_divisor,
  input  logic               i_bit,
  output logic [width_d:0]   o_partial,
  output logic               o_qbit
);
  logic [width_d:0] w_trial;
  logic [width_d:0] w_divisor;

  // The incoming partial is always below the divisor, so the shift never loses a set bit.
  always_comb begin
    w_trial   = (i_partial << 1) | {{width_d{1'b0}}, i_bit};
    w_divisor = {1'b0, i_divisor};
    o_qbit    = (w_trial >= w_divisor);
    o_partial = o_qbit ? (w_trial - w_divisor) : w_trial;
  end
endmodule

// File: rtl/seq_divide.sv
// Iterative radix-2 restoring divider, signed or unsigned per operand,
// width_n+2 enabled cycles per operation.
module seq_divide
  import seq_divide_pkg::*;
#(
  parameter int width_n = 8,
  parameter int width_d = 8
) (
  input  logic clock0,
  input  logic aclr0,
  input  logic ena0,
  seq_divide_if.slave bus
);
  localparam int CNT_W = clog2(width_n + 1);

  state_t               r_state;
  logic [CNT_W-1:0]     r_count;
  logic [width_n-1:0]   r_shift;
  logic [width_d-1:0]   r_den_mag;
  logic [width_d:0]     r_partial;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic [width_d-1:0]   r_numer_raw;
  logic [NUM_FLAGS-1:0] r_pend;
  logic [NUM_FLAGS-1:0] r_flags;
  logic                 r_ready;
  logic                 r_done;
  logic [width_n-1:0]   r_quotient;
  logic [width_d-1:0]   r_remain;

  logic                 w_numer_neg;
  logic                 w_denom_neg;
  logic [width_n-1:0]   w_numer_mag;
  logic [width_d-1:0]   w_denom_mag;
  logic                 w_is_ovf;
  logic [width_d:0]     w_step_partial;
  logic                 w_qbit;
  logic [width_d:0]     w_rem_fix;

  assign w_numer_neg = bus.signn & bus.numer[width_n-1];
  assign w_denom_neg = bus.signd & bus.denom[width_d-1];
  assign w_numer_mag = w_numer_neg ? -bus.numer : bus.numer;
  assign w_denom_mag = w_denom_neg ? -bus.denom : bus.denom;
  assign w_is_ovf    = bus.signn & bus.signd
                     & (bus.numer == {1'b1, {(width_n-1){1'b0}}})
                     & (bus.denom == {width_d{1'b1}});
  assign w_rem_fix   = r_neg_r ? -r_partial : r_partial;

  seq_divide_step #(.width_d(width_d)) u_step (
    .i_partial (r_partial),
    .i_divisor (r_den_mag),
    .i_bit     (r_shift[width_n-1]),
    .o_partial (w_step_partial),
    .o_qbit    (w_qbit)
  );

  always_ff @(posedge clock0 or posedge aclr0) begin
    if (aclr0) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_shift     <= '0;
      r_den_mag   <= '0;
      r_partial   <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_numer_raw <= '0;
      r_pend      <= '0;
      r_flags     <= '0;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remain    <= '0;
    end else if (ena0) begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_shift             <= w_numer_mag;
            r_den_mag           <= w_denom_mag;
            r_partial           <= '0;
            r_neg_q             <= w_numer_neg ^ w_denom_neg;
            r_neg_r             <= w_numer_neg;
            r_numer_raw         <= width_d'(bus.numer);
            r_pend[FLAG_DZ]     <= (bus.denom == '0);
            r_pend[FLAG_OV]     <= w_is_ovf;
            r_count             <= CNT_W'(width_n);
            r_ready             <= 1'b0;
            r_state             <= ST_CALC;
          end
        end
        ST_CALC: begin
          // Quotient bits fill the numerator shift register from the bottom.
          r_partial <= w_step_partial;
          r_shift   <= {r_shift[width_n-2:0], w_qbit};
          r_count   <= r_count - CNT_W'(1);
          if (r_count == CNT_W'(1)) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (r_pend[FLAG_DZ]) begin
            r_quotient <= '1;
            r_remain   <= r_numer_raw;
          end else begin
            r_quotient <= r_neg_q ? -r_shift : r_shift;
            r_remain   <= width_d'(w_rem_fix);
          end
          r_flags <= r_pend;
          r_done  <= 1'b1;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ready       = r_ready;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quotient;
  assign bus.remain      = r_remain;
  assign bus.div_by_zero = r_flags[FLAG_DZ];
  assign bus.overflow    = r_flags[FLAG_OV];
endmodule
